wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_wb_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back vs. a deferred-write FIFO with pending scoreboard.
// Optional starvation guard enabled by defining WB_ARB_STARVE_GUARD_EN.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [3:0]  pipe_waddr,
  input  logic [23:0] pipe_wdata,
  output logic        pipe_ack,
  input  logic        def_valid,
  output logic        def_ready,
  input  logic [3:0]  def_waddr,
  input  logic [23:0] def_wdata,
  input  logic        iss_valid,
  input  logic [3:0]  iss_waddr,
  output logic        reg_we,
  output logic [3:0]  reg_waddr,
  output logic [23:0] reg_wdata,
  output logic [15:0] pending,
  output logic        stall_out,
  output logic [2:0]  fifo_count
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [3:0]  waddr;
    logic [23:0] wdata;
  } wr_t;

  wr_t           mem_q [FIFO_DEPTH];
  wr_t           mem_d [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   pend_q, pend_d;
  logic          reg_we_q, reg_we_d;
  logic [3:0]    reg_waddr_q, reg_waddr_d;
  logic [23:0]   reg_wdata_q, reg_wdata_d;
  logic          stall_q;
  logic          fifo_ne, push, grant_pipe, grant_fifo;
  wr_t           head;

  always_comb begin
    fifo_ne    = (cnt_q != '0);
    head       = mem_q[rd_ptr_q];
    def_ready  = !rst && (cnt_q < CW'(FIFO_DEPTH));
    push       = def_valid && def_ready;
    grant_pipe = 1'b0;
    grant_fifo = 1'b0;
    if (!rst) begin
      if (stall_q)      grant_fifo = fifo_ne;
      else if (pipe_we) grant_pipe = 1'b1;
      else              grant_fifo = fifo_ne;
    end
    pipe_ack = grant_pipe;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{waddr: def_waddr, wdata: def_wdata};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (grant_fifo) rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(grant_fifo);

    // Clear on pop first so a same-cycle issue to that register wins.
    pend_d = pend_q;
    if (grant_fifo) pend_d[head.waddr] = 1'b0;
    if (iss_valid)  pend_d[iss_waddr]  = 1'b1;

    reg_we_d    = grant_pipe || grant_fifo;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    if (grant_pipe) begin
      reg_waddr_d = pipe_waddr;
      reg_wdata_d = pipe_wdata;
    end else if (grant_fifo) begin
      reg_waddr_d = head.waddr;
      reg_wdata_d = head.wdata;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

`ifdef WB_ARB_STARVE_GUARD_EN
  logic [1:0] starve_q, starve_d;
  logic       stall_d;

  // Third pipeline win over a waiting head forces one FIFO slot next cycle.
  always_comb begin
    starve_d = starve_q;
    stall_d  = 1'b0;
    if (grant_fifo || !fifo_ne) begin
      starve_d = '0;
    end else if (grant_pipe) begin
      starve_d = starve_q + 2'd1;
      stall_d  = (starve_q == 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end
`else
  assign stall_q = 1'b0;
`endif

  assign reg_we     = reg_we_q;
  assign reg_waddr  = reg_waddr_q;
  assign reg_wdata  = reg_wdata_q;
  assign pending    = pend_q;
  assign stall_out  = stall_q;
  assign fifo_count = 3'(cnt_q);
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, idle drain, priority, full FIFO, scoreboard, starvation, mid-run reset.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [3:0]  pipe_waddr;
  logic [23:0] pipe_wdata;
  logic        pipe_ack;
  logic        def_valid;
  logic        def_ready;
  logic [3:0]  def_waddr;
  logic [23:0] def_wdata;
  logic        iss_valid;
  logic [3:0]  iss_waddr;
  logic        reg_we;
  logic [3:0]  reg_waddr;
  logic [23:0] reg_wdata;
  logic [15:0] pending;
  logic        stall_out;
  logic [2:0]  fifo_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  wb_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata), .pipe_ack(pipe_ack),
    .def_valid(def_valid), .def_ready(def_ready), .def_waddr(def_waddr), .def_wdata(def_wdata),
    .iss_valid(iss_valid), .iss_waddr(iss_waddr),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .pending(pending), .stall_out(stall_out), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
    def_valid = 0; def_waddr = 0; def_wdata = 0;
    iss_valid = 0; iss_waddr = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    pipe_we = 1; def_valid = 1; def_waddr = 4'd3;
    step(); step();
    vec_cnt++; if (def_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_def_ready got %0b want 0", def_ready); end
    vec_cnt++; if (pipe_ack !== 1'b0) begin err_cnt++; $display("FAIL rst_pipe_ack got %0b want 0", pipe_ack); end
    vec_cnt++; if ({reg_we, reg_waddr, reg_wdata} !== 29'd0) begin err_cnt++; $display("FAIL rst_reg got we=%0b a=%0d d=%h want 0", reg_we, reg_waddr, reg_wdata); end
    vec_cnt++; if (pending !== 16'h0 || fifo_count !== 3'd0 || stall_out !== 1'b0) begin err_cnt++; $display("FAIL rst_state got pend=%h cnt=%0d stall=%0b want 0", pending, fifo_count, stall_out); end
    idle_inputs(); rst = 0;
    step();
    vec_cnt++; if (reg_we !== 1'b0 || fifo_count !== 3'd0) begin err_cnt++; $display("FAIL rst_exit got we=%0b cnt=%0d want 0 0", reg_we, fifo_count); end
  endtask

  task automatic test_idle();
    def_valid = 1; def_waddr = 4'd5; def_wdata = 24'h00ABCD;
    #1;
    vec_cnt++; if (def_ready !== 1'b1) begin err_cnt++; $display("FAIL idle_ready got %0b want 1", def_ready); end
    step(); def_valid = 0;
    vec_cnt++; if (fifo_count !== 3'd1 || reg_we !== 1'b0) begin err_cnt++; $display("FAIL idle_c2 got cnt=%0d we=%0b want 1 0", fifo_count, reg_we); end
    step();
    vec_cnt++; if (reg_we !== 1'b1 || reg_waddr !== 4'd5 || reg_wdata !== 24'h00ABCD) begin err_cnt++; $display("FAIL idle_wr got we=%0b a=%0d d=%h want 1 5 00abcd", reg_we, reg_waddr, reg_wdata); end
    vec_cnt++; if (fifo_count !== 3'd0) begin err_cnt++; $display("FAIL idle_cnt got %0d want 0", fifo_count); end
    step();
    vec_cnt++; if (reg_we !== 1'b0) begin err_cnt++; $display("FAIL idle_nogrant got %0b want 0", reg_we); end
  endtask

  task automatic test_priority();
    pipe_we = 1; pipe_waddr = 4'd2; pipe_wdata = 24'h000111;
    def_valid = 1; def_waddr = 4'd7; def_wdata = 24'h000777;
    step(); def_valid = 0;
    vec_cnt++; if (reg_we !== 1'b1 || reg_waddr !== 4'd2 || reg_wdata !== 24'h000111) begin err_cnt++; $display("FAIL prio_r2 got we=%0b a=%0d d=%h want 1 2 000111", reg_we, reg_waddr, reg_wdata); end
    pipe_waddr = 4'd3; pipe_wdata = 24'h000333;
    #1;
    vec_cnt++; if (pipe_ack !== 1'b1) begin err_cnt++; $display("FAIL prio_ack got %0b want 1", pipe_ack); end
    step(); pipe_we = 0;
    vec_cnt++; if (reg_waddr !== 4'd3 || fifo_count !== 3'd1) begin err_cnt++; $display("FAIL prio_r3 got a=%0d cnt=%0d want 3 1", reg_waddr, fifo_count); end
    step();
    vec_cnt++; if (reg_we !== 1'b1 || reg_waddr !== 4'd7 || reg_wdata !== 24'h000777) begin err_cnt++; $display("FAIL prio_r7 got we=%0b a=%0d d=%h want 1 7 000777", reg_we, reg_waddr, reg_wdata); end
    step();
  endtask

  task automatic test_full();
    pipe_we = 1; pipe_waddr = 4'd1; pipe_wdata = 24'h111111;
    for (int k = 0; k < 4; k++) begin
      def_valid = 1; def_waddr = 4'(8 + k); def_wdata = 24'h000800 + 24'(k);
      #1;
      vec_cnt++; if (def_ready !== 1'b1) begin err_cnt++; $display("FAIL full_ready%0d got %0b want 1", k, def_ready); end
      step();
    end
    def_waddr = 4'd12; def_wdata = 24'h00000C;
    #1;
    vec_cnt++; if (def_ready !== 1'b0 || fifo_count !== 3'd4) begin err_cnt++; $display("FAIL full_state got rdy=%0b cnt=%0d want 0 4", def_ready, fifo_count); end
    step();
    vec_cnt++; if (fifo_count !== 3'd4) begin err_cnt++; $display("FAIL full_refuse got cnt=%0d want 4", fifo_count); end
    def_valid = 0; pipe_we = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      vec_cnt++;
      if (reg_we !== 1'b1 || reg_waddr !== 4'(8 + k) || reg_wdata !== 24'h000800 + 24'(k) || fifo_count !== 3'(3 - k)) begin
        err_cnt++; $display("FAIL full_drain%0d got we=%0b a=%0d d=%h cnt=%0d want 1 %0d %h %0d", k, reg_we, reg_waddr, reg_wdata, fifo_count, 8 + k, 24'h000800 + 24'(k), 3 - k);
      end
    end
    step();
    vec_cnt++; if (reg_we !== 1'b0) begin err_cnt++; $display("FAIL full_done got %0b want 0", reg_we); end
  endtask

  task automatic test_scoreboard();
    iss_valid = 1; iss_waddr = 4'd9;
    step(); iss_valid = 0;
    vec_cnt++; if (pending !== 16'h0200) begin err_cnt++; $display("FAIL sb_set got %h want 0200", pending); end
    pipe_we = 1; pipe_waddr = 4'd9; pipe_wdata = 24'h123456;
    step(); pipe_we = 0;
    vec_cnt++; if (pending !== 16'h0200 || reg_waddr !== 4'd9) begin err_cnt++; $display("FAIL sb_pipe got pend=%h a=%0d want 0200 9", pending, reg_waddr); end
    def_valid = 1; def_waddr = 4'd9; def_wdata = 24'h000999;
    step(); def_valid = 0;
    iss_valid = 1; iss_waddr = 4'd9;
    step(); iss_valid = 0;
    vec_cnt++; if (pending !== 16'h0200 || reg_we !== 1'b1 || reg_waddr !== 4'd9) begin err_cnt++; $display("FAIL sb_same got pend=%h we=%0b a=%0d want 0200 1 9", pending, reg_we, reg_waddr); end
    def_valid = 1;
    step(); def_valid = 0;
    step();
    vec_cnt++; if (pending !== 16'h0000) begin err_cnt++; $display("FAIL sb_clear got %h want 0000", pending); end
    step();
  endtask

  task automatic test_starve();
    pipe_we = 1; pipe_waddr = 4'd1; pipe_wdata = 24'h000001;
    def_valid = 1; def_waddr = 4'd4; def_wdata = 24'h000444;
    step(); def_valid = 0;
`ifdef WB_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 3; k++) begin
      #1;
      vec_cnt++; if (pipe_ack !== 1'b1 || stall_out !== 1'b0) begin err_cnt++; $display("FAIL starve_pre%0d got ack=%0b stall=%0b want 1 0", k, pipe_ack, stall_out); end
      step();
    end
    vec_cnt++; if (stall_out !== 1'b1 || pipe_ack !== 1'b0) begin err_cnt++; $display("FAIL starve_stall got stall=%0b ack=%0b want 1 0", stall_out, pipe_ack); end
    step();
    vec_cnt++; if (reg_waddr !== 4'd4 || reg_wdata !== 24'h000444 || stall_out !== 1'b0 || pipe_ack !== 1'b1) begin err_cnt++; $display("FAIL starve_wr got a=%0d d=%h stall=%0b ack=%0b want 4 000444 0 1", reg_waddr, reg_wdata, stall_out, pipe_ack); end
    pipe_we = 0;
    step();
`else
    for (int k = 0; k < 6; k++) begin
      step();
      vec_cnt++; if (reg_waddr !== 4'd1 || stall_out !== 1'b0 || fifo_count !== 3'd1) begin err_cnt++; $display("FAIL starve_hold%0d got a=%0d stall=%0b cnt=%0d want 1 0 1", k, reg_waddr, stall_out, fifo_count); end
    end
    pipe_we = 0;
    step();
    vec_cnt++; if (reg_we !== 1'b1 || reg_waddr !== 4'd4) begin err_cnt++; $display("FAIL starve_late got we=%0b a=%0d want 1 4", reg_we, reg_waddr); end
`endif
    step();
  endtask

  task automatic test_reset_mid();
    pipe_we = 1; pipe_waddr = 4'd2; pipe_wdata = 24'h000002;
    for (int k = 0; k < 3; k++) begin
      def_valid = 1; def_waddr = 4'(k); def_wdata = 24'h00A000 + 24'(k);
      iss_valid = (k < 2); iss_waddr = (k == 0) ? 4'd4 : 4'd9;
      step();
    end
    iss_valid = 0;
    vec_cnt++; if (fifo_count !== 3'd3 || pending !== 16'h0210) begin err_cnt++; $display("FAIL mid_pre got cnt=%0d pend=%h want 3 0210", fifo_count, pending); end
    rst = 1;
    #1;
    vec_cnt++; if (def_ready !== 1'b0 || pipe_ack !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_hs got rdy=%0b ack=%0b want 0 0", def_ready, pipe_ack); end
    step();
    vec_cnt++; if (fifo_count !== 3'd0 || pending !== 16'h0 || reg_we !== 1'b0) begin err_cnt++; $display("FAIL mid_rst got cnt=%0d pend=%h we=%0b want 0 0 0", fifo_count, pending, reg_we); end
    rst = 0; idle_inputs();
    step();
    vec_cnt++; if (reg_we !== 1'b0 || fifo_count !== 3'd0) begin err_cnt++; $display("FAIL mid_after got we=%0b cnt=%0d want 0 0", reg_we, fifo_count); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_priority();
`ifndef WB_ARB_STARVE_GUARD_EN
    test_full();
`endif
    test_scoreboard();
    test_starve();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
